iob_wishbone2iob_reg: RTL and testbench

Registered Wishbone-classic slave to IOb-native master bridge: the successor to the combinational Wishbone/IOb bridge for paths that need registered boundaries, slave-error propagation and bus-hang protection. It sits between a Wishbone master (e.g. the Ethernet MAC DMA port) and the IOb system interconnect. It captures one Wishbone request, holds it on the IOb side until `ready_i`, then returns a single-cycle registered `wb_ack_o` or `wb_err_o`. An optional watchdog terminates requests the IOb slave never answers.

---
 rtl/iob_wishbone2iob_reg.sv | 145 ++++++++++++++
 tb/tb_iob_wishbone2iob_reg.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_wishbone2iob_reg.sv
// Registered Wishbone-classic slave to IOb-native master bridge.
// One outstanding request; registered ack/err; optional watchdog.
//
// Optional feature macro: WB2IOB_TIMEOUT_EN (watchdog on unanswered REQ).
//
// Ports:
//   clk_i, rst_n_i           : clock, synchronous active-low reset
//   wb_adr_i .. wb_dat_i     : Wishbone request (slave side)
//   wb_ack_o, wb_err_o       : single-cycle registered termination
//   wb_dat_o                 : registered read data
//   valid_o, addr_o, wdata_o : IOb request (registered, frozen in REQ)
//   wstrb_o, sel_o           : write strobes (0 on reads), byte selects
//   rdata_i, ready_i, err_i  : IOb response; err_i qualified by ready_i
module iob_wishbone2iob_reg #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 256
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic [ADDR_W-1:0]   wb_adr_i,
   input  logic [DATA_W/8-1:0] wb_sel_i,
   input  logic                wb_we_i,
   input  logic                wb_cyc_i,
   input  logic                wb_stb_i,
   input  logic [DATA_W-1:0]   wb_dat_i,
   output logic                wb_ack_o,
   output logic                wb_err_o,
   output logic [DATA_W-1:0]   wb_dat_o,
   output logic                valid_o,
   output logic [ADDR_W-1:0]   addr_o,
   output logic [DATA_W-1:0]   wdata_o,
   output logic [DATA_W/8-1:0] wstrb_o,
   output logic [DATA_W/8-1:0] sel_o,
   input  logic [DATA_W-1:0]   rdata_i,
   input  logic                ready_i,
   input  logic                err_i
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_RESP
   } state_t;

   state_t r_state;
   logic   r_abort;
   logic   r_we;
   logic   w_abort;
   logic   w_expire;

   // A cycle with cyc low counts toward abort in that same cycle.
   assign w_abort = r_abort | ~wb_cyc_i;

`ifdef WB2IOB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] r_cnt;

   // Expiry fires on the TIMEOUT-th consecutive unanswered REQ cycle.
   assign w_expire = (r_state == S_REQ)
                   & (r_cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_cnt <= '0;
      end else if (r_state != S_REQ) begin
         r_cnt <= '0;
      end else if (!ready_i) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end
`else
   logic w_unused_tmo;

   assign w_unused_tmo = (TIMEOUT > 1);
   assign w_expire     = 1'b0;
`endif

   // ack/err are registered on the edge that enters RESP, so they
   // are high exactly during the single RESP cycle.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_state  <= S_IDLE;
         r_abort  <= 1'b0;
         r_we     <= 1'b0;
         wb_ack_o <= 1'b0;
         wb_err_o <= 1'b0;
         wb_dat_o <= '0;
         valid_o  <= 1'b0;
         addr_o   <= '0;
         wdata_o  <= '0;
         wstrb_o  <= '0;
         sel_o    <= '0;
      end else begin
         wb_ack_o <= 1'b0;
         wb_err_o <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (wb_cyc_i & wb_stb_i) begin
                  addr_o  <= wb_adr_i;
                  wdata_o <= wb_dat_i;
                  sel_o   <= wb_sel_i;
                  wstrb_o <= wb_we_i ? wb_sel_i : '0;
                  r_we    <= wb_we_i;
                  r_abort <= 1'b0;
                  valid_o <= 1'b1;
                  r_state <= S_REQ;
               end
            end
            S_REQ: begin
               r_abort <= w_abort;
               if (ready_i) begin
                  valid_o <= 1'b0;
                  if (!r_we) begin
                     wb_dat_o <= rdata_i;
                  end
                  if (w_abort) begin
                     r_state <= S_IDLE;
                  end else begin
                     wb_ack_o <= ~err_i;
                     wb_err_o <= err_i;
                     r_state  <= S_RESP;
                  end
               end else if (w_expire) begin
                  valid_o <= 1'b0;
                  if (w_abort) begin
                     r_state <= S_IDLE;
                  end else begin
                     wb_err_o <= 1'b1;
                     r_state  <= S_RESP;
                  end
               end
            end
            S_RESP: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iob_wishbone2iob_reg.sv
// Scoreboard bench for iob_wishbone2iob_reg.
// Transaction-level model; monitor checks IOb requests and WB responses.
module tb_iob_wishbone2iob_reg;

   localparam int TMO = 4;

   logic        clk;
   logic        rst_n_i;
   logic [31:0] wb_adr_i;
   logic [3:0]  wb_sel_i;
   logic        wb_we_i;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic [31:0] wb_dat_i;
   logic        wb_ack_o;
   logic        wb_err_o;
   logic [31:0] wb_dat_o;
   logic        valid_o;
   logic [31:0] addr_o;
   logic [31:0] wdata_o;
   logic [3:0]  wstrb_o;
   logic [3:0]  sel_o;
   logic [31:0] rdata_i;
   logic        ready_i;
   logic        err_i;

   iob_wishbone2iob_reg #(
      .ADDR_W (32),
      .DATA_W (32),
      .TIMEOUT(TMO)
   ) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n_i),
      .wb_adr_i(wb_adr_i),
      .wb_sel_i(wb_sel_i),
      .wb_we_i (wb_we_i),
      .wb_cyc_i(wb_cyc_i),
      .wb_stb_i(wb_stb_i),
      .wb_dat_i(wb_dat_i),
      .wb_ack_o(wb_ack_o),
      .wb_err_o(wb_err_o),
      .wb_dat_o(wb_dat_o),
      .valid_o (valid_o),
      .addr_o  (addr_o),
      .wdata_o (wdata_o),
      .wstrb_o (wstrb_o),
      .sel_o   (sel_o),
      .rdata_i (rdata_i),
      .ready_i (ready_i),
      .err_i   (err_i)
   );

   typedef struct {
      logic [31:0] adr;
      logic [31:0] wdat;
      logic [3:0]  wstrb;
      logic [3:0]  sel;
      int          c1;
      int          len;
   } req_t;

   typedef struct {
      bit          err;
      logic [31:0] dat;
      int          cyc;
   } rsp_t;

   req_t        rq[$];
   rsp_t        sq[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   logic [31:0] m_dat = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   // Monitor
   logic pv = 1'b0;
   int   vcnt = 0;
   req_t cur;
   rsp_t e;

   always @(negedge clk) begin
      if (wb_ack_o && wb_err_o) chk("ack_and_err", 1, 0);
      if (wb_ack_o || wb_err_o) begin
         if (sq.size() == 0) begin
            chk("unexpected_rsp", {wb_ack_o, wb_err_o}, 0);
         end else begin
            e = sq.pop_front();
            chk("rsp_err", wb_err_o, e.err);
            chk("rsp_ack", wb_ack_o, !e.err);
            chk("rsp_cycle", cyc, e.cyc);
            chk("rsp_dat", wb_dat_o, e.dat);
         end
      end
      if (valid_o && !pv) begin
         vcnt = 0;
         if (rq.size() == 0) begin
            chk("unexpected_valid", valid_o, 0);
         end else begin
            cur = rq.pop_front();
            chk("valid_cycle", cyc, cur.c1);
         end
      end
      if (valid_o) begin
         vcnt++;
         chk("req_addr_wdata", {addr_o, wdata_o}, {cur.adr, cur.wdat});
         chk("req_wstrb_sel", {wstrb_o, sel_o}, {cur.wstrb, cur.sel});
      end
      if (!valid_o && pv) chk("valid_len", vcnt, cur.len);
      pv = valid_o;
   end

   task automatic push_req(input bit we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel,
                           input int c, input int len);
      req_t q;
      q.adr   = adr;
      q.wdat  = dat;
      q.sel   = sel;
      q.wstrb = we ? sel : 4'h0;
      q.c1    = c + 1;
      q.len   = len;
      rq.push_back(q);
   endtask

   task automatic start(input bit we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        output int c);
      @(posedge clk);
      #1;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_we_i  = we;
      wb_adr_i = adr;
      wb_dat_i = dat;
      wb_sel_i = sel;
      c = cyc;
   endtask

   // REQ-cycle noise on WB inputs checks that request regs stay frozen.
   task automatic noise();
      wb_adr_i = $urandom;
      wb_dat_i = $urandom;
      wb_sel_i = 4'($urandom);
      wb_we_i  = 1'($urandom);
   endtask

   task automatic finish_txn();
      @(posedge clk);
      #1;
      ready_i  = 1'b0;
      err_i    = 1'($urandom);
      rdata_i  = $urandom;
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
   endtask

   // w: wait cycles before ready; drop<0: no abort, else cyc drops
   // on REQ cycle index drop (drop < w).
   task automatic txn(input bit we, input logic [31:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel,
                      input int w, input logic [31:0] rd,
                      input bit er, input int drop);
      int   c;
      rsp_t s;
      start(we, adr, dat, sel, c);
      push_req(we, adr, dat, sel, c, w + 1);
      for (int i = 0; i <= w; i++) begin
         @(posedge clk);
         #1;
         noise();
         if (drop >= 0 && i >= drop) begin
            wb_cyc_i = 1'b0;
            wb_stb_i = 1'b0;
         end
         ready_i = (i == w);
         rdata_i = (i == w) ? rd : $urandom;
         err_i   = (i == w) ? er : 1'($urandom);
      end
      if (!we) m_dat = rd;
      if (drop < 0) begin
         s.err = er;
         s.dat = m_dat;
         s.cyc = c + 2 + w;
         sq.push_back(s);
      end
      finish_txn();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         wb_cyc_i = 1'($urandom);
         wb_stb_i = 1'b0;
         ready_i  = 1'($urandom);
         err_i    = 1'($urandom);
         rdata_i  = $urandom;
      end
      @(posedge clk);
      #1;
      wb_cyc_i = 1'b0;
      ready_i  = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, valid_o, 0);
      chk({tag, "_ack_err"}, {wb_ack_o, wb_err_o}, 0);
      chk({tag, "_dat"}, wb_dat_o, 0);
      chk({tag, "_addr"}, addr_o, 0);
      chk({tag, "_wdata"}, wdata_o, 0);
      chk({tag, "_strb_sel"}, {wstrb_o, sel_o}, 0);
   endtask

   task automatic reset_mid();
      int c;
      start(1'b0, 32'h300, 32'h0, 4'hF, c);
      push_req(1'b0, 32'h300, 32'h0, 4'hF, c, 1);
      @(posedge clk);
      #1;
      rst_n_i = 1'b0;
      ready_i = 1'b0;
      @(posedge clk);
      #1;
      rst_n_i  = 1'b1;
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      m_dat    = '0;
      @(negedge clk);
      chk_zero("rstmid");
   endtask

`ifdef WB2IOB_TIMEOUT_EN
   task automatic tmo_txn(input bit we, input logic [31:0] adr,
                          input int drop);
      int   c;
      rsp_t s;
      start(we, adr, 32'h5A5A0000, 4'hC, c);
      push_req(we, adr, 32'h5A5A0000, 4'hC, c, TMO);
      for (int i = 0; i < TMO; i++) begin
         @(posedge clk);
         #1;
         noise();
         if (drop >= 0 && i >= drop) begin
            wb_cyc_i = 1'b0;
            wb_stb_i = 1'b0;
         end
         ready_i = 1'b0;
      end
      if (drop < 0) begin
         s.err = 1'b1;
         s.dat = m_dat;
         s.cyc = c + 1 + TMO;
         sq.push_back(s);
      end
      @(posedge clk);
      #1;
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      ready_i  = 1'b1;
      err_i    = 1'b0;
      rdata_i  = 32'hBADBAD00;
      repeat (2) @(posedge clk);
      #1;
      ready_i = 1'b0;
   endtask
`endif

   initial begin
      rst_n_i  = 1'b0;
      wb_adr_i = '0;
      wb_sel_i = '0;
      wb_we_i  = 1'b0;
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_dat_i = '0;
      rdata_i  = '0;
      ready_i  = 1'b0;
      err_i    = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_zero("reset");
      rst_n_i = 1'b1;

      txn(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 2, 32'h0, 1'b0, -1);
      txn(1'b0, 32'h204, 32'h0, 4'h3, 0, 32'h12345678, 1'b0, -1);
      txn(1'b0, 32'h208, 32'h0, 4'hF, 1, 32'hCAFEF00D, 1'b1, -1);
      txn(1'b1, 32'h20C, 32'h11112222, 4'h5, 3, 32'h0, 1'b0, 1);
      txn(1'b1, 32'h210, 32'h33334444, 4'hA, 0, 32'h0, 1'b0, -1);
      idle(2);
      reset_mid();
      idle(1);
      txn(1'b0, 32'h400, 32'h0, 4'hF, 20, 32'h0BADF00D, 1'b0, -1);
`ifdef WB2IOB_TIMEOUT_EN
      tmo_txn(1'b0, 32'h500, -1);
      tmo_txn(1'b1, 32'h504, 1);
      txn(1'b0, 32'h508, 32'h0, 4'hF, TMO - 1, 32'h600DCAFE, 1'b0, -1);
`endif
      for (int n = 0; n < 60; n++) begin
         bit          we;
         int          w;
         int          drop;
         we   = 1'($urandom);
         w    = $urandom_range(0, 5);
         drop = -1;
         if (w > 0 && $urandom_range(0, 5) == 0) begin
            drop = $urandom_range(0, w - 1);
         end
         txn(we, $urandom, $urandom, 4'($urandom), w, $urandom,
             1'($urandom_range(0, 3) == 0), drop);
         if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 2));
      end

      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("req_queue_left", rq.size(), 0);
      chk("rsp_queue_left", sq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
